// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle instruction sequencer with handshake,
// memory-wait timeout, illegal-opcode trap and retire counter.
module multicycle_ctrl #(
    parameter int OPCODE_W    = 6,
    parameter int MEM_TIMEOUT = 15,
    parameter int PERF_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    input  logic                trap_clr,
    output logic [1:0]          ALUOp,
    output logic                RegDst,
    output logic                RegWrite,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                Branch,
    output logic                Jump,
    output logic                JumpReg,
    output logic                PCWrite,
    output logic                done,
    output logic                trap,
    output logic                trap_cause,
    output logic [PERF_W-1:0]   retired_count,
    output logic [2:0]          state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_BEQ = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_J   = OPCODE_W'(6);
    localparam logic [OPCODE_W-1:0] OP_JR  = OPCODE_W'(7);
    localparam logic [OPCODE_W-1:0] OP_LW  = OPCODE_W'(8);
    localparam logic [OPCODE_W-1:0] OP_SW  = OPCODE_W'(9);

    state_t              state;
    logic [OPCODE_W-1:0] op_q;
    logic [CW-1:0]       tcnt;
    logic                cause_q;

    logic is_add, is_sub, is_beq, is_j, is_jr, is_lw, is_sw, legal;

    assign is_add = (op_q == OP_ADD);
    assign is_sub = (op_q == OP_SUB);
    assign is_beq = (op_q == OP_BEQ);
    assign is_j   = (op_q == OP_J);
    assign is_jr  = (op_q == OP_JR);
    assign is_lw  = (op_q == OP_LW);
    assign is_sw  = (op_q == OP_SW);
    assign legal  = is_add | is_sub | is_beq | is_j | is_jr | is_lw | is_sw;

    // State sequencing, opcode latch, memory timeout and retire counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            op_q          <= '0;
            tcnt          <= '0;
            cause_q       <= 1'b0;
            retired_count <= '0;
        end else begin
            if (done) begin
                retired_count <= retired_count + PERF_W'(1);
            end
            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        op_q  <= opcode;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (legal) begin
                        state <= S_EXEC;
                    end else begin
                        state   <= S_TRAP;
                        cause_q <= 1'b0;
                    end
                end
                S_EXEC: begin
                    unique case (1'b1)
                        is_add, is_sub: state <= S_WB;
                        is_lw, is_sw: begin
                            state <= S_MEM;
                            tcnt  <= '0;
                        end
                        default: state <= S_IDLE;
                    endcase
                end
                S_MEM: begin
                    // a late mem_ready on the limit cycle still completes
                    if (mem_ready) begin
                        state <= is_lw ? S_WB : S_IDLE;
                    end else begin
                        tcnt <= tcnt + CW'(1);
                        if (tcnt == CW'(MEM_TIMEOUT - 1)) begin
                            state   <= S_TRAP;
                            cause_q <= 1'b1;
                        end
                    end
                end
                S_WB: state <= S_IDLE;
                S_TRAP: begin
                    if (trap_clr) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Control outputs decoded from current state and latched opcode
    always_comb begin
        instr_ready = 1'b0;
        ALUOp       = 2'b00;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        Branch      = 1'b0;
        Jump        = 1'b0;
        JumpReg     = 1'b0;
        PCWrite     = 1'b0;
        done        = 1'b0;
        trap        = 1'b0;
        case (state)
            S_IDLE: instr_ready = 1'b1;
            S_EXEC: begin
                if (is_sub) ALUOp = 2'b10;
                if (is_beq) ALUOp = 2'b01;
                Branch  = is_beq;
                Jump    = is_j;
                JumpReg = is_jr;
                PCWrite = (is_beq & zero) | is_j | is_jr;
                done    = is_beq | is_j | is_jr;
            end
            S_MEM: begin
                MemRead  = is_lw;
                MemWrite = is_sw;
                done     = is_sw & mem_ready;
            end
            S_WB: begin
                RegWrite = 1'b1;
                RegDst   = is_add | is_sub;
                done     = 1'b1;
            end
            S_TRAP: trap = 1'b1;
            default: ;
        endcase
    end

    assign trap_cause = cause_q;
    assign state_dbg  = state;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle successor to the single-cycle opcode decoder. It sequences each instruction through DECODE/EXEC/MEM/WB states and drives the same control-signal set per cycle.
- Adds an instruction handshake, memory-wait stalls with timeout, and an illegal-opcode trap with a clear input.
- Also adds a retired-instruction counter.
- Sits between the instruction fetch buffer and the datapath/ALU/data-memory interface.

Parameters:
- OPCODE_W, 6, opcode width; supported encodings are zero-extended to this width.
- MEM_TIMEOUT, 15, maximum number of MEM-state cycles waiting for mem_ready before trapping (must be >= 1).
- PERF_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  opcode on `opcode` is valid
- instr_ready  out  1  controller can accept an instruction (high only in IDLE)
- opcode  in  OPCODE_W  instruction opcode
- zero  in  1  ALU zero flag, sampled in EXEC for BEQ
- mem_ready  in  1  data memory has completed the access
- trap_clr  in  1  leave TRAP state
- ALUOp  out  2  ALU operation class
- RegDst, RegWrite, MemRead, MemWrite, Branch, Jump, JumpReg  out  1 each  datapath controls
- PCWrite  out  1  load the PC with a branch or jump target
- done  out  1  one-cycle pulse when an instruction retires
- trap  out  1  high while in TRAP
- trap_cause  out  1  0 = illegal opcode, 1 = memory timeout; valid while trap = 1
- retired_count  out  PERF_W  number of retired instructions, wraps
- state_dbg  out  3  current state encoding

Behaviour:
- **Opcodes:**
  - ADD = 0x00, SUB = 0x02, BEQ = 0x04, J = 0x06, JR = 0x07, LW = 0x08, SW = 0x09.
  - Every other value is illegal.
- **States:** IDLE = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 5. Encodings 6 and 7 are unreachable; if entered, return to IDLE.
- **Reset:**
  - state = IDLE, latched opcode = 0, timeout counter = 0, trap_cause = 0, retired_count = 0.
  - Hence after reset: instr_ready = 1 and every other output = 0.
- **Output timing:** All control outputs are combinational from the registered state and the latched opcode. The one exception is PCWrite in EXEC for BEQ, which also uses `zero`.
- **IDLE:**
  - instr_ready = 1.
  - If instr_valid is high: latch opcode and go to DECODE next cycle.
- **DECODE** (1 cycle): illegal opcode -> TRAP with trap_cause = 0; otherwise -> EXEC. All controls are 0 in this state.
- **EXEC** (1 cycle), by opcode:
  - ADD: ALUOp = 00 -> WB.
  - SUB: ALUOp = 10 -> WB.
  - LW and SW: ALUOp = 00 (address calculation) -> MEM, and the timeout counter is cleared.
  - BEQ: ALUOp = 01, Branch = 1, PCWrite = zero, done = 1 -> IDLE.
  - J: Jump = 1, PCWrite = 1, done = 1 -> IDLE.
  - JR: JumpReg = 1, PCWrite = 1, done = 1 -> IDLE.
- **MEM:**
  - MemRead = 1 for LW, MemWrite = 1 for SW, held for every MEM cycle. The counter increments each cycle that mem_ready = 0.
  - mem_ready = 1: LW -> WB; SW -> IDLE with done = 1 in this cycle.
  - Counter reaches MEM_TIMEOUT with mem_ready still 0 -> TRAP with trap_cause = 1.
  - If mem_ready = 1 in the same cycle the limit is reached, mem_ready wins (no trap).
- **WB** (1 cycle):
  - RegWrite = 1, done = 1 -> IDLE.
  - RegDst = 1 for ADD/SUB, 0 for LW.
- **TRAP:**
  - trap = 1, instr_ready = 0, all datapath controls 0.
  - Stays in TRAP until trap_clr = 1, then goes to IDLE next cycle. trap_cause holds its value until the next trap entry.
- **retired_count:**
  - Increments by 1 on the clock edge ending each cycle where done = 1; wraps modulo 2^PERF_W.
  - Trapped instructions are not counted.
- **Latency from the accept cycle (cycle 0):**
  - ADD/SUB: WB at cycle 3.
  - BEQ/J/JR: retire at cycle 2.
  - LW: WB at cycle 4 + N, where N = number of cycles mem_ready was low.
  - SW: retires at cycle 3 + N.
  - The next instruction can be accepted in the cycle after retirement.
- **Boundary conditions:**
  - instr_valid outside IDLE is ignored; opcode is not re-latched.
  - trap_clr outside TRAP is ignored.
  - rst has priority over everything. Asserting rst mid-MEM or mid-WB aborts the instruction: outputs are deasserted from the next cycle and done is not pulsed.

Test Plan:
1. Reset, then instr_valid = 1 with opcode = 0x00 at cycle 0 -> cycle 3: RegWrite = 1, RegDst = 1, ALUOp = 00 at cycle 2, done = 1; retired_count = 1; instr_ready = 1 at cycle 4.
2. LW (0x08) with mem_ready low for 3 MEM cycles, then high -> MemRead = 1 for 4 cycles; WB at cycle 7 with RegDst = 0, RegWrite = 1. SW (0x09) under the same stimulus -> MemWrite = 1 for 4 cycles, done = 1 at cycle 6, RegWrite never asserted.
3. BEQ (0x04) with zero = 1 -> EXEC: ALUOp = 01, Branch = 1, PCWrite = 1, done = 1. Repeat with zero = 0 -> PCWrite = 0, done = 1.
4. Opcode 0x0F -> cycle 1 DECODE; cycle 2 trap = 1, trap_cause = 0; instr_valid ignored. trap_clr pulse -> IDLE; retired_count unchanged.
5. LW with mem_ready held low -> TRAP after 15 MEM cycles with trap_cause = 1. Separately, mem_ready = 1 on exactly the 15th MEM cycle -> WB, no trap.
6. Assert rst during MEM of SW -> MemWrite = 0 and state_dbg = 0 the next cycle, no done pulse, retired_count = 0.
7. Preload retired_count via 2^PERF_W retirements (use PERF_W = 4, 16 J instructions) -> count wraps to 0.
